// File: rtl/spi_slave_mcu_multi.sv
// MCU-facing SPI slave (mode 0) serving a framed packet of NUM_SENSORS IMU channels
// with sequence number, optional XOR checksum, short-read abort and overrun detection.
`timescale 1ns/1ps
module spi_slave_mcu_multi #(
    parameter int         NUM_SENSORS = 2,
    parameter logic [7:0] HEADER      = 8'hAA,
    parameter bit         CHECKSUM_EN = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     sck,
    input  logic                     sdi,
    output logic                     sdo,
    input  logic                     load,
    output logic                     done,
    input  logic [NUM_SENSORS-1:0]   quat_valid,
    input  logic [64*NUM_SENSORS-1:0] quat_data,
    input  logic [NUM_SENSORS-1:0]   gyro_valid,
    input  logic [48*NUM_SENSORS-1:0] gyro_data,
    output logic                     overrun,
    output logic                     err_short,
    output logic [7:0]               seq_num
);

    localparam int BODY_BYTES = 2 + 15 * NUM_SENSORS;
    localparam int PKT_BYTES  = BODY_BYTES + (CHECKSUM_EN ? 1 : 0);
    localparam int PKT_BITS   = 8 * PKT_BYTES;
    localparam int CNT_W      = $clog2(PKT_BITS + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(PKT_BITS);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(PKT_BITS + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READY = 2'd1,
        SHIFT = 2'd2
    } state_t;

    function automatic logic [7:0] xor_fold_f(input logic [8*BODY_BYTES-1:0] body);
        logic [7:0] acc;
        acc = 8'h00;
        for (int i = 0; i < BODY_BYTES; i++) begin
            acc = acc ^ body[8*i +: 8];
        end
        return acc;
    endfunction

    logic [1:0]             sck_sync_r, load_sync_r, sdi_sync_r;
    logic                   sck_prev_r, load_prev_r;
    logic                   sck_rise_s, sck_fall_s, load_rise_s, load_fall_s;
    logic                   unused_sdi_s;

    logic [63:0]            quat_shadow_r [NUM_SENSORS];
    logic [47:0]            gyro_shadow_r [NUM_SENSORS];
    logic [NUM_SENSORS-1:0] quat_flag_r, gyro_flag_r, snap_quat_r, snap_gyro_r;
    logic [NUM_SENSORS-1:0] quat_flag_next_s, gyro_flag_next_s;
    logic                   overrun_r, overrun_next_s, overrun_hit_s;

    state_t                 state_r;
    logic [PKT_BITS-1:0]    pkt_shift_r;
    logic [PKT_BITS-1:0]    pkt_s;
    logic [8*BODY_BYTES-1:0] body_s;
    logic                   sdo_r, done_r, err_short_r;
    logic [7:0]             seq_num_r;
    logic [CNT_W-1:0]       bit_cnt_r;
    logic                   in_shift_s, complete_s;

    assign sck_rise_s   =  sck_sync_r[1]  & ~sck_prev_r;
    assign sck_fall_s   = ~sck_sync_r[1]  &  sck_prev_r;
    assign load_rise_s  =  load_sync_r[1] & ~load_prev_r;
    assign load_fall_s  = ~load_sync_r[1] &  load_prev_r;
    assign unused_sdi_s = ^sdi_sync_r;

    // Two-flop synchronisers and edge-detect history for the SPI pins
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sck_sync_r  <= 2'b00;
            load_sync_r <= 2'b00;
            sdi_sync_r  <= 2'b00;
            sck_prev_r  <= 1'b0;
            load_prev_r <= 1'b0;
        end else begin
            sck_sync_r  <= {sck_sync_r[0], sck};
            load_sync_r <= {load_sync_r[0], load};
            sdi_sync_r  <= {sdi_sync_r[0], sdi};
            sck_prev_r  <= sck_sync_r[1];
            load_prev_r <= load_sync_r[1];
        end
    end

    // Next-state of sticky flags and overrun; snapshot flags only shield a strobe while shifting
    always_comb begin
        in_shift_s = (state_r == SHIFT);
        complete_s = in_shift_s & load_fall_s & (bit_cnt_r == CNT_FULL);
        if (complete_s) begin
            quat_flag_next_s = (quat_flag_r & ~snap_quat_r) | quat_valid;
            gyro_flag_next_s = (gyro_flag_r & ~snap_gyro_r) | gyro_valid;
        end else begin
            quat_flag_next_s = quat_flag_r | quat_valid;
            gyro_flag_next_s = gyro_flag_r | gyro_valid;
        end
        overrun_hit_s =
            |((quat_valid & quat_flag_r & ~(snap_quat_r & {NUM_SENSORS{in_shift_s}})) |
              (gyro_valid & gyro_flag_r & ~(snap_gyro_r & {NUM_SENSORS{in_shift_s}})));
        if (complete_s) begin
            overrun_next_s = overrun_hit_s;
        end else begin
            overrun_next_s = overrun_r | overrun_hit_s;
        end
    end

    // Shadow registers, sticky flags and overrun
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_SENSORS; k++) begin
                quat_shadow_r[k] <= 64'h0;
                gyro_shadow_r[k] <= 48'h0;
            end
            quat_flag_r <= '0;
            gyro_flag_r <= '0;
            overrun_r   <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_SENSORS; k++) begin
                if (quat_valid[k]) begin
                    quat_shadow_r[k] <= quat_data[64*k +: 64];
                end
                if (gyro_valid[k]) begin
                    gyro_shadow_r[k] <= gyro_data[48*k +: 48];
                end
            end
            quat_flag_r <= quat_flag_next_s;
            gyro_flag_r <= gyro_flag_next_s;
            overrun_r   <= overrun_next_s;
        end
    end

    // Packet body assembly, byte 0 in the MSBs
    always_comb begin
        body_s = '0;
        body_s[8*BODY_BYTES-1 -: 16] = {HEADER, seq_num_r};
        for (int k = 0; k < NUM_SENSORS; k++) begin
            body_s[8*BODY_BYTES-17-120*k -: 120] =
                {quat_shadow_r[k], gyro_shadow_r[k], 6'b000000, gyro_flag_r[k], quat_flag_r[k]};
        end
    end

    generate
        if (CHECKSUM_EN) begin : g_csum
            assign pkt_s = {body_s, xor_fold_f(body_s)};
        end else begin : g_no_csum
            assign pkt_s = body_s;
        end
    endgenerate

    // Read FSM: snapshot on load rise, shift on sck, classify read on load fall
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            pkt_shift_r <= '0;
            sdo_r       <= 1'b0;
            done_r      <= 1'b0;
            err_short_r <= 1'b0;
            seq_num_r   <= 8'd0;
            bit_cnt_r   <= '0;
            snap_quat_r <= '0;
            snap_gyro_r <= '0;
        end else begin
            err_short_r <= 1'b0;
            case (state_r)
                IDLE, READY: begin
                    if (load_rise_s) begin
                        state_r     <= SHIFT;
                        pkt_shift_r <= pkt_s;
                        sdo_r       <= pkt_s[PKT_BITS-1];
                        bit_cnt_r   <= '0;
                        done_r      <= 1'b0;
                        snap_quat_r <= quat_flag_r;
                        snap_gyro_r <= gyro_flag_r;
                    end else if ((|quat_flag_r) || (|gyro_flag_r)) begin
                        state_r <= READY;
                        done_r  <= 1'b1;
                        sdo_r   <= 1'b0;
                    end else begin
                        state_r <= IDLE;
                        done_r  <= 1'b0;
                        sdo_r   <= 1'b0;
                    end
                end
                SHIFT: begin
                    done_r <= 1'b0;
                    if (load_fall_s) begin
                        if (complete_s) begin
                            seq_num_r <= seq_num_r + 8'd1;
                        end else begin
                            err_short_r <= 1'b1;
                        end
                        sdo_r <= 1'b0;
                        if ((|quat_flag_next_s) || (|gyro_flag_next_s)) begin
                            state_r <= READY;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= IDLE;
                        end
                    end else begin
                        // zeros shifted in supply sdo = 0 for any excess bits
                        if (sck_fall_s) begin
                            pkt_shift_r <= {pkt_shift_r[PKT_BITS-2:0], 1'b0};
                            sdo_r       <= pkt_shift_r[PKT_BITS-2];
                        end
                        if (sck_rise_s && (bit_cnt_r != CNT_SAT)) begin
                            bit_cnt_r <= bit_cnt_r + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    sdo_r   <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign sdo       = sdo_r;
    assign done      = done_r;
    assign overrun   = overrun_r;
    assign err_short = err_short_r;
    assign seq_num   = seq_num_r;

endmodule

// File: tb/tb_spi_slave_mcu_multi.sv
// Scoreboard bench for spi_slave_mcu_multi: a bench-side model predicts each packet at
// load rise, the bytes are queued and compared as the MCU-side shifter collects them.
`timescale 1ns/1ps
module tb_spi_slave_mcu_multi;

    localparam int N  = 2;
    localparam int L  = 2 + 15 * N + 1;
    localparam int NB = 8 * L;

    logic clk = 1'b0;
    logic rst_n, sck, sdi, load;
    logic sdo, done, overrun, err_short;
    logic [7:0] seq_num;
    logic [N-1:0] quat_valid, gyro_valid;
    logic [64*N-1:0] quat_data;
    logic [48*N-1:0] gyro_data;

    spi_slave_mcu_multi #(.NUM_SENSORS(N), .HEADER(8'hAA), .CHECKSUM_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .sck(sck), .sdi(sdi), .sdo(sdo), .load(load), .done(done),
        .quat_valid(quat_valid), .quat_data(quat_data), .gyro_valid(gyro_valid),
        .gyro_data(gyro_data), .overrun(overrun), .err_short(err_short), .seq_num(seq_num)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int err_pulses = 0;

    logic [63:0] m_quat [N];
    logic [47:0] m_gyro [N];
    logic [N-1:0] m_qf, m_gf, m_sq, m_sg;
    logic [7:0]  m_seq;
    logic        m_ovr;
    bit          m_reading;
    logic [7:0]  exp_q [$];
    logic [7:0]  rx [L];
    logic [7:0]  prev_rx [L];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (err_short === 1'b1) err_pulses++;
    end

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_quat[k] = 64'h0;
            m_gyro[k] = 48'h0;
        end
        m_qf = '0; m_gf = '0; m_sq = '0; m_sg = '0;
        m_seq = 8'h00; m_ovr = 1'b0; m_reading = 1'b0;
        exp_q.delete();
    endtask

    task automatic strobe(input int ch, input bit is_quat, input logic [63:0] data);
        if (is_quat) begin
            quat_data[64*ch +: 64] = data;
            quat_valid[ch] = 1'b1;
            if (m_qf[ch] && !(m_reading && m_sq[ch])) m_ovr = 1'b1;
            m_quat[ch] = data;
            m_qf[ch] = 1'b1;
        end else begin
            gyro_data[48*ch +: 48] = data[47:0];
            gyro_valid[ch] = 1'b1;
            if (m_gf[ch] && !(m_reading && m_sg[ch])) m_ovr = 1'b1;
            m_gyro[ch] = data[47:0];
            m_gf[ch] = 1'b1;
        end
        tick(1);
        quat_valid = '0;
        gyro_valid = '0;
    endtask

    task automatic push_expected();
        logic [7:0] b [L];
        logic [7:0] cs;
        b[0] = 8'hAA;
        b[1] = m_seq;
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < 8; i++) b[2 + 15*k + i]  = m_quat[k][63 - 8*i -: 8];
            for (int i = 0; i < 6; i++) b[10 + 15*k + i] = m_gyro[k][47 - 8*i -: 8];
            b[16 + 15*k] = {6'b000000, m_gf[k], m_qf[k]};
        end
        cs = 8'h00;
        for (int i = 0; i < L - 1; i++) cs = cs ^ b[i];
        b[L-1] = cs;
        for (int i = 0; i < L; i++) exp_q.push_back(b[i]);
    endtask

    task automatic read_pkt(input int nbits, input int strobe_bit, input int rst_bit,
                            input logic [63:0] mid_data);
        logic [7:0] e;
        load = 1'b1;
        m_sq = m_qf;
        m_sg = m_gf;
        m_reading = 1'b1;
        push_expected();
        tick(4);
        for (int i = 0; i < L; i++) rx[i] = 8'h00;
        for (int b = 0; b < nbits; b++) begin
            if (b == rst_bit) begin
                rst_n = 1'b0;
                load  = 1'b0;
                sck   = 1'b0;
                tick(1);
                check_val("rst_sdo", {31'd0, sdo}, 32'd0);
                check_val("rst_done", {31'd0, done}, 32'd0);
                check_val("rst_seq", {24'd0, seq_num}, 32'd0);
                rst_n = 1'b1;
                model_reset();
                tick(4);
                return;
            end
            rx[b/8][7 - (b % 8)] = sdo;
            if (b == strobe_bit) strobe(1, 1'b1, mid_data);
            sck = 1'b1;
            tick(4);
            sck = 1'b0;
            tick(4);
        end
        load = 1'b0;
        tick(6);
        m_reading = 1'b0;
        for (int i = 0; i < L; i++) begin
            e = exp_q.pop_front();
            if (i < nbits / 8) check_val($sformatf("byte%0d", i), {24'd0, rx[i]}, {24'd0, e});
        end
        if (nbits == NB) begin
            m_qf  = m_qf & ~m_sq;
            m_gf  = m_gf & ~m_sg;
            m_seq = m_seq + 8'd1;
            m_ovr = 1'b0;
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        logic [7:0] cs;
        rst_n = 1'b0; sck = 1'b0; sdi = 1'b0; load = 1'b0;
        quat_valid = '0; gyro_valid = '0; quat_data = '0; gyro_data = '0;
        model_reset();
        tick(3);
        rst_n = 1'b1;
        tick(2);
        check_val("reset_sdo", {31'd0, sdo}, 32'd0);
        check_val("reset_done", {31'd0, done}, 32'd0);
        check_val("reset_overrun", {31'd0, overrun}, 32'd0);
        check_val("reset_err", {31'd0, err_short}, 32'd0);
        check_val("reset_seq", {24'd0, seq_num}, 32'd0);

        // Test 1: all channels, full read
        strobe(0, 1'b1, {16'h4000, 16'h1000, 16'h2000, 16'h3000});
        strobe(0, 1'b0, {16'h0000, 16'h0100, 16'h0200, 16'h0300});
        strobe(1, 1'b1, {16'h5000, 16'h1100, 16'h2200, 16'h3300});
        strobe(1, 1'b0, {16'h0000, 16'h0400, 16'h0500, 16'h0600});
        tick(2);
        check_val("t1_done_before", {31'd0, done}, 32'd1);
        read_pkt(NB, -1, -1, 64'h0);
        check_val("t1_b0", {24'd0, rx[0]}, 32'hAA);
        check_val("t1_b1", {24'd0, rx[1]}, 32'h00);
        check_val("t1_b2", {24'd0, rx[2]}, 32'h40);
        check_val("t1_b3", {24'd0, rx[3]}, 32'h00);
        check_val("t1_b17", {24'd0, rx[17]}, 32'h50);
        check_val("t1_b18", {24'd0, rx[18]}, 32'h00);
        check_val("t1_b16", {24'd0, rx[16]}, 32'h03);
        check_val("t1_b31", {24'd0, rx[31]}, 32'h03);
        cs = 8'h00;
        for (int i = 0; i < L - 1; i++) cs = cs ^ rx[i];
        check_val("t1_csum", {24'd0, rx[32]}, {24'd0, cs});
        check_val("t1_done_after", {31'd0, done}, 32'd0);
        check_val("t1_seq", {24'd0, seq_num}, 32'h01);

        // Test 2: single quat strobe
        strobe(0, 1'b1, {16'h6000, 16'h1000, 16'h2000, 16'h3000});
        tick(1);
        check_val("t2_done_2cyc", {31'd0, done}, 32'd1);
        read_pkt(NB, -1, -1, 64'h0);
        check_val("t2_b16", {24'd0, rx[16]}, 32'h01);
        check_val("t2_b31", {24'd0, rx[31]}, 32'h00);
        check_val("t2_done_after", {31'd0, done}, 32'd0);

        // Test 3: short read then retry
        strobe(0, 1'b0, {16'h0000, 16'h0007, 16'h0008, 16'h0009});
        tick(2);
        e0 = err_pulses;
        read_pkt(100, -1, -1, 64'h0);
        check_val("t3_err_pulses", err_pulses - e0, 32'd1);
        check_val("t3_done", {31'd0, done}, 32'd1);
        check_val("t3_seq_kept", {24'd0, seq_num}, {24'd0, m_seq});
        check_val("t3_seq_abs", {24'd0, seq_num}, 32'h02);
        for (int i = 0; i < L; i++) prev_rx[i] = rx[i];
        e0 = err_pulses;
        read_pkt(NB, -1, -1, 64'h0);
        for (int i = 0; i < 12; i++)
            check_val($sformatf("t3_reread%0d", i), {24'd0, rx[i]}, {24'd0, prev_rx[i]});
        check_val("t3_no_err_full", err_pulses - e0, 32'd0);
        check_val("t3_seq_after", {24'd0, seq_num}, 32'h03);

        // Test 4: strobe during SHIFT lands in the next packet
        strobe(0, 1'b1, {16'h1234, 16'h0001, 16'h0002, 16'h0003});
        tick(2);
        read_pkt(NB, 50, -1, {16'h7777, 16'h0011, 16'h0022, 16'h0033});
        check_val("t4_b16", {24'd0, rx[16]}, 32'h01);
        check_val("t4_b31_old", {24'd0, rx[31]}, 32'h00);
        check_val("t4_done", {31'd0, done}, 32'd1);
        check_val("t4_overrun", {31'd0, overrun}, 32'd0);
        read_pkt(NB, -1, -1, 64'h0);
        check_val("t4_b31_new", {24'd0, rx[31]}, 32'h01);
        check_val("t4_b17_new", {24'd0, rx[17]}, 32'h77);
        check_val("t4_done_after", {31'd0, done}, 32'd0);

        // Test 5: overrun on a double strobe
        strobe(0, 1'b1, {16'h1111, 16'h0001, 16'h0002, 16'h0003});
        strobe(0, 1'b1, {16'hBEEF, 16'h0004, 16'h0005, 16'h0006});
        check_val("t5_overrun", {31'd0, overrun}, 32'd1);
        check_val("t5_overrun_model", {31'd0, overrun}, {31'd0, m_ovr});
        read_pkt(NB, -1, -1, 64'h0);
        check_val("t5_b2", {24'd0, rx[2]}, 32'hBE);
        check_val("t5_b3", {24'd0, rx[3]}, 32'hEF);
        check_val("t5_overrun_clr", {31'd0, overrun}, 32'd0);

        // Test 6: reset during SHIFT
        strobe(0, 1'b1, {16'h2468, 16'h0001, 16'h0002, 16'h0003});
        strobe(1, 1'b0, {16'h0000, 16'h0101, 16'h0202, 16'h0303});
        tick(2);
        read_pkt(NB, -1, 40, 64'h0);
        check_val("t6_done_post", {31'd0, done}, 32'd0);
        read_pkt(NB, -1, -1, 64'h0);
        check_val("t6_b16", {24'd0, rx[16]}, 32'h00);
        check_val("t6_b31", {24'd0, rx[31]}, 32'h00);
        check_val("t6_b32", {24'd0, rx[32]}, 32'hAA);
        check_val("t6_seq", {24'd0, seq_num}, 32'h01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
